// File: rtl/segment_sequencer_if.sv
// Bundle of button pulses, configuration and segment outputs for segment_sequencer.
interface segment_sequencer_if #(
    parameter int NUM_SEGMENTS = 6,
    parameter int PERIOD_WIDTH = 24
);
    logic                    btn_next_segment_re;
    logic                    btn_mode_re;
    logic                    btn_dir_re;
    logic                    bounce_en;
    logic [PERIOD_WIDTH-1:0] period;
    logic [NUM_SEGMENTS-1:0] segments;
    logic [1:0]              current_mode;
    logic                    tick;

    modport master (
        output btn_next_segment_re, btn_mode_re, btn_dir_re, bounce_en, period,
        input  segments, current_mode, tick
    );

    modport slave (
        input  btn_next_segment_re, btn_mode_re, btn_dir_re, bounce_en, period,
        output segments, current_mode, tick
    );
endinterface

// File: rtl/segment_sequencer.sv
// Segment bar driver: manual/fill/blink/auto modes, stepped by button or programmable tick.
module segment_sequencer #(
    parameter int NUM_SEGMENTS = 6,
    parameter int PERIOD_WIDTH = 24
) (
    input logic             clk,
    input logic             async_nreset,
    segment_sequencer_if.slave bus
);
    localparam int PW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_SEGMENTS - 1);

    typedef enum logic [1:0] {MANUAL = 2'b00, FILL = 2'b01, BLINK = 2'b10, AUTO = 2'b11} mode_t;

    mode_t                   mode, mode_nxt;
    logic [PW-1:0]           pos, pos_nxt;
    logic                    dir, dir_nxt;
    logic                    phase, phase_nxt;
    logic [PERIOD_WIDTH-1:0] cnt, cnt_nxt, eff_m1;
    logic                    running, fire, step, tick_nxt;
    logic [NUM_SEGMENTS-1:0] seg_nxt;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mode             <= MANUAL;
            pos              <= '0;
            dir              <= 1'b0;
            phase            <= 1'b0;
            cnt              <= '0;
            bus.tick         <= 1'b0;
            bus.current_mode <= 2'b00;
            bus.segments     <= NUM_SEGMENTS'(1);
        end else begin
            mode             <= mode_nxt;
            pos              <= pos_nxt;
            dir              <= dir_nxt;
            phase            <= phase_nxt;
            cnt              <= cnt_nxt;
            bus.tick         <= tick_nxt;
            bus.current_mode <= mode;
            bus.segments     <= seg_nxt;
        end
    end

    always_comb begin
        mode_nxt  = mode;
        pos_nxt   = pos;
        dir_nxt   = dir ^ bus.btn_dir_re;
        phase_nxt = phase;
        cnt_nxt   = '0;
        step      = 1'b0;
        tick_nxt  = 1'b0;
        // period of 0 behaves as 1, so the wrap threshold never underflows
        eff_m1    = (bus.period == '0) ? '0 : bus.period - PERIOD_WIDTH'(1);
        running   = (mode == BLINK) || (mode == AUTO);
        fire      = running && (cnt >= eff_m1);

        if (bus.btn_mode_re) begin
            mode_nxt  = mode_t'(mode + 2'd1);
            pos_nxt   = '0;
            phase_nxt = 1'b0;
        end else begin
            tick_nxt = fire;
            if (running && !fire) cnt_nxt = cnt + PERIOD_WIDTH'(1);
            if (mode == BLINK && fire) phase_nxt = ~phase;
            step = ((mode == MANUAL || mode == FILL) && bus.btn_next_segment_re) ||
                   (mode == AUTO && fire);
            if (step) begin
                if (!dir_nxt) begin
                    if (pos != LAST)       pos_nxt = pos + PW'(1);
                    else if (bus.bounce_en) begin
                        dir_nxt = 1'b1;
                        pos_nxt = LAST - PW'(1);
                    end else               pos_nxt = '0;
                end else begin
                    if (pos != '0)         pos_nxt = pos - PW'(1);
                    else if (bus.bounce_en) begin
                        dir_nxt = 1'b0;
                        pos_nxt = PW'(1);
                    end else               pos_nxt = LAST;
                end
            end
        end
    end

    // segment image of the current state; registered so pins change one edge later
    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            case (mode)
                FILL:    seg_nxt[i] = (PW'(i) <= pos);
                BLINK:   seg_nxt[i] = phase;
                default: seg_nxt[i] = (PW'(i) == pos);
            endcase
        end
    end
endmodule
